tanh_share_arb: RTL and testbench
=================================

Name: tanh_share_arb

Overview:
- Shares one fixed-latency tanh datapath among N_REQ requesters, e.g. the LSTM gate/cell-state paths of the modulation classifier.
- Arbitrates round-robin and issues at most one operand per cycle.
- Tracks each operand's owner through the tanh pipeline.
- Returns each result to its owner as a one-cycle valid pulse.
- Sits between the requesters and the tanh instance; owns the tanh instance's tanh_in, consumes its tanh_out.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- DW, 18: data width, signed fixed point (1 sign, 5 int, 12 frac).
- TANH_LAT, 3: clock cycles from tanh_in to matching tanh_out on the tanh instance (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  per-requester operand valid
- req_data  in  N_REQ*DW  operands; requester i at bits [i*DW +: DW]
- req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
- tanh_in  out  DW  operand to tanh instance (registered)
- tanh_out  in  DW  result from tanh instance
- rsp_valid  out  N_REQ  one-hot result pulse to owning requester
- rsp_data  out  DW  result, common to all requesters, qualified by rsp_valid
- busy  out  1  high while any operation is in flight

Behaviour:
- Reset (rst=1 at a clk edge), all registered state cleared:
  - tanh_in=0, rsp_valid=0, rsp_data=0, busy=0.
  - Round-robin pointer=0.
  - Tag pipeline emptied; in-flight results are discarded and never reported.
- req_ready is combinational from req_valid and the pointer:
  - At most one bit high, and only for a requester whose req_valid is high.
  - All zero during rst.
- Arbitration:
  - Search starts at the pointer index and proceeds ascending with wrap-around: ptr, ptr+1, ..., N_REQ-1, 0, ...
  - The first requester with req_valid set wins.
  - After a grant to i, pointer <= (i+1) mod N_REQ.
  - No grant leaves the pointer unchanged.
- Issue: on a grant to i, tanh_in <= req_data[i] at the same edge. With no grant, tanh_in <= 0.
- Throughput: one issue per cycle, with back-to-back grants possible every cycle.
- Fairness: a continuously valid requester waits at most N_REQ-1 cycles.
- Tag pipeline: depth TANH_LAT+1 (1 for the tanh_in register, TANH_LAT for the tanh instance), holding {valid, id}.
  - Stage 0 is loaded on the issue edge.
  - Stages shift every cycle; no stall.
- Response:
  - When the last tag stage is valid, rsp_valid[id] <= 1 and rsp_data <= tanh_out.
  - Otherwise rsp_valid <= 0 and rsp_data holds its last value.
  - Issue-to-response latency is TANH_LAT+2 cycles from the req handshake edge.
- Requesters cannot backpressure responses. A requester must accept rsp_valid whenever it arrives.
- A requester may issue again before its prior result returns. Results return in issue order.
- busy = OR of all tag-stage valid bits, registered alongside.
- Simultaneous issue and retire in the same cycle are both performed.
- Requester i dropping req_valid without a handshake is legal; no state changes.
- req_data is ignored when there is no grant.
- No arithmetic on data; widths pass through unchanged.

Decomposition:
- Shared package tanh_pkg:
  - DW, the fixed-point field widths (sign 1, int 5, frac 12).
  - ID width = clog2(N_REQ) (min 1).
  - Constant ONE_Q = 18'h01000 (1.0).
- Sub-module rr_arbiter (N parameter): req vector + pointer -> one-hot grant, grant index, grant_any.
  - Reused later for other shared units (sigmoid, MAC).
- Tag pipeline and response mux remain in tanh_share_arb.

Test Plan:
- Bench setup: tanh stub = TANH_LAT-deep delay line (tanh_out = tanh_in delayed), so results are exact.
- Single request: after reset, requester 2 presents 18'h00800 (0.5) for one handshake -> tanh_in=18'h00800 the next cycle; rsp_valid=4'b0100 with rsp_data=18'h00800 exactly TANH_LAT+2 cycles after the handshake; busy high in between.
- All four valid continuously with data 18'h01000+i -> grants in order 0,1,2,3,0,...; one rsp_valid per cycle in the same order with the matching data; no gaps.
- Fairness: requesters 0 and 3 always valid, pointer at 1 -> grant 3 then 0 alternately; neither waits more than 3 cycles.
- Back-to-back same owner: only requester 1 valid, data 18'h3FFFF then 18'h2F3FF on consecutive cycles -> two consecutive rsp_valid=4'b0010 pulses, in order.
- Reset mid-flight: issue 3 operands, assert rst one cycle later -> no rsp_valid pulses afterwards; busy=0, tanh_in=0, pointer=0 (the next grant with all valid goes to requester 0).
- Idle: no req_valid for 20 cycles -> req_ready=0, tanh_in=0, rsp_valid=0, busy=0 throughout.

Source files
------------

// File: rtl/tanh_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tanh_pkg
// Description : Shared fixed-point widths, constants and helpers for the
//               shared tanh datapath and its arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tanh_pkg;

  // Q5.12 signed fixed point: 1 sign bit, 5 integer bits, 12 fraction bits
  localparam int SIGN_W = 1;
  localparam int INT_W  = 5;
  localparam int FRAC_W = 12;
  localparam int DW     = SIGN_W + INT_W + FRAC_W;

  // 1.0 in Q5.12
  localparam logic [DW-1:0] ONE_Q = 18'h01000;

  // Width of a requester index; never below one bit
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches the request
//               vector upward from the pointer with wrap-around and returns
//               the first hit as a one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import tanh_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;

  // Walk ptr, ptr+1, ... (mod N); the first requester found wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int off = 0; off < N; off++) begin
      w_sum = {1'b0, ptr} + (IW+1)'(off);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      w_cand = w_sum[IW-1:0];
      if (!grant_any && req[w_cand]) begin
        grant_any     = 1'b1;
        grant_idx     = w_cand;
        grant[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tanh_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tanh_share_arb
// Description : Shares one fixed-latency tanh instance among N_REQ
//               requesters. Round-robin issue of one operand per cycle, an
//               owner-tag pipeline matching the tanh latency, and a one-hot
//               result pulse back to the owning requester.
// Revision    : 1.0 - initial release
// ============================================================================
module tanh_share_arb
  import tanh_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DW       = tanh_pkg::DW,
  parameter int TANH_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [DW-1:0]         tanh_in,
  input  logic [DW-1:0]         tanh_out,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  busy
);

  localparam int IW    = id_width(N_REQ);
  // One stage for the tanh_in register plus TANH_LAT inside the tanh unit
  localparam int DEPTH = TANH_LAT + 1;

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_grant_idx;
  logic             w_grant_any;
  logic             w_issue;
  logic [IW-1:0]    w_ptr_nxt;
  logic [DW-1:0]    w_issue_data;
  logic [N_REQ-1:0] w_rsp_onehot;

  logic [IW-1:0]    r_ptr;
  logic [DEPTH-1:0] r_tag_v;
  logic [IW-1:0]    r_tag_id [DEPTH];

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  // Grants are suppressed while reset is asserted so nothing handshakes
  assign req_ready = rst ? '0 : w_grant;
  assign w_issue   = w_grant_any & ~rst;
  assign w_ptr_nxt = (w_grant_idx == IW'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  // Select the granted requester's operand; zero when nobody is granted
  always_comb begin
    w_issue_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_issue_data = req_data[i*DW +: DW];
      end
    end
  end

  // Round-robin pointer moves just past the winner; holds when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Operand register feeding the tanh instance
  always_ff @(posedge clk) begin
    if (rst) begin
      tanh_in <= '0;
    end else begin
      tanh_in <= w_issue ? w_issue_data : '0;
    end
  end

  // Owner tags shift every cycle alongside the operand through the tanh unit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_v     <= {r_tag_v[DEPTH-2:0], w_issue};
      r_tag_id[0] <= w_grant_idx;
      for (int k = 1; k < DEPTH; k++) begin
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  // Busy reflects the tag valid bits as they will be after this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= |{r_tag_v[DEPTH-2:0], w_issue};
    end
  end

  assign w_rsp_onehot = N_REQ'(1) << r_tag_id[DEPTH-1];

  // Retire: pulse the owner and capture the tanh result; data holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (r_tag_v[DEPTH-1]) begin
      rsp_valid <= w_rsp_onehot;
      rsp_data  <= tanh_out;
    end else begin
      rsp_valid <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tanh_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_tanh_share_arb
// Description : Scoreboard bench for tanh_share_arb with a delay-line tanh
//               stub so results equal operands exactly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tanh_share_arb;

  localparam int N_REQ    = 4;
  localparam int DW       = 18;
  localparam int TANH_LAT = 3;
  localparam int LATENCY  = TANH_LAT + 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ*DW-1:0] req_data = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [DW-1:0]       tanh_in;
  logic [DW-1:0]       tanh_out;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic                busy;

  typedef struct {
    logic [N_REQ-1:0] v;
    logic [DW-1:0]    d;
    int               due;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  bit            chk_en = 1'b0;
  int            mptr = 0;
  logic [DW-1:0] exp_tin = '0;
  logic [DW-1:0] dl [TANH_LAT];

  tanh_share_arb #(
    .N_REQ    (N_REQ),
    .DW       (DW),
    .TANH_LAT (TANH_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tanh_in   (tanh_in),
    .tanh_out  (tanh_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // tanh stand-in: pure TANH_LAT-cycle delay
  always_ff @(posedge clk) begin
    dl[0] <= tanh_in;
    for (int k = 1; k < TANH_LAT; k++) dl[k] <= dl[k-1];
  end
  assign tanh_out = dl[TANH_LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Arbitration model: predicts grants, pushes expected responses
  always @(negedge clk) begin
    #1;
    if (chk_en) begin : model_blk
      logic [N_REQ-1:0] g;
      int               idx;
      int               c;
      bit               found;
      check("tanh_in", tanh_in, exp_tin);
      g = '0; idx = 0; found = 1'b0;
      if (!rst) begin
        for (int off = 0; off < N_REQ; off++) begin
          c = (mptr + off) % N_REQ;
          if (!found && req_valid[c]) begin
            found = 1'b1; idx = c; g[c] = 1'b1;
          end
        end
      end
      check("req_ready_model", req_ready, g);
      if (rst) begin
        sb.delete();
        mptr    = 0;
        exp_tin = '0;
      end else if (found) begin
        sb.push_back('{v: g, d: req_data[idx*DW +: DW], due: cyc + LATENCY});
        mptr    = (idx + 1) % N_REQ;
        exp_tin = req_data[idx*DW +: DW];
      end else begin
        exp_tin = '0;
      end
    end
  end

  // Response monitor: pops the scoreboard when a result is due
  always @(negedge clk) begin
    if (chk_en) begin : mon_blk
      exp_t e;
      bit   b;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("rsp_valid", rsp_valid, e.v);
        check("rsp_data", rsp_data, e.d);
      end else begin
        check("rsp_idle", rsp_valid, '0);
      end
      b = 1'b0;
      foreach (sb[i]) if (sb[i].due > cyc) b = 1'b1;
      check("busy", busy, b);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic expect_ready(input logic [N_REQ-1:0] e, input string name);
    @(negedge clk);
    check(name, req_ready, e);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_tanh_in", tanh_in, '0);
    check("reset_rsp_valid", rsp_valid, '0);
    check("reset_rsp_data", rsp_data, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", req_ready, '0);
    step();

    // Single request from requester 2
    req_valid = 4'b0100;
    set_data(2, 18'h00800);
    expect_ready(4'b0100, "single_grant");
    step();
    req_valid = '0;
    @(negedge clk);
    check("single_tanh_in", tanh_in, 18'h00800);
    check("single_busy", busy, 1'b1);
    step();
    idle(LATENCY + 2);

    // Reset pulse to return the pointer to 0
    rst = 1'b1;
    step();
    rst = 1'b0;

    // All four valid: grants 0,1,2,3,0,...
    for (int i = 0; i < N_REQ; i++) set_data(i, 18'h01000 + DW'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      expect_ready(4'b0001 << (k % 4), "rr_all");
      step();
    end
    idle(LATENCY + 2);

    // Fairness: move pointer to 1, then 0 and 3 both valid
    req_valid = 4'b0001;
    set_data(0, 18'h00100);
    expect_ready(4'b0001, "fair_setup");
    step();
    set_data(3, 18'h00103);
    req_valid = 4'b1001;
    for (int k = 0; k < 6; k++) begin
      expect_ready((k % 2 == 0) ? 4'b1000 : 4'b0001, "fair_alt");
      step();
    end
    idle(LATENCY + 2);

    // Back-to-back from requester 1
    req_valid = 4'b0010;
    set_data(1, 18'h3FFFF);
    expect_ready(4'b0010, "b2b_first");
    step();
    set_data(1, 18'h2F3FF);
    expect_ready(4'b0010, "b2b_second");
    step();
    idle(LATENCY + 2);

    // Reset mid-flight: pointer is at 2, so grants go 2,3,0
    for (int i = 0; i < N_REQ; i++) set_data(i, 18'h02000 + DW'(i));
    req_valid = 4'b1111;
    expect_ready(4'b0100, "mid_g0");
    step();
    expect_ready(4'b1000, "mid_g1");
    step();
    expect_ready(4'b0001, "mid_g2");
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 1'b0);
    check("mid_tanh_in", tanh_in, '0);
    check("mid_rsp_valid", rsp_valid, '0);
    step();
    idle(LATENCY + 2);
    req_valid = 4'b1111;
    expect_ready(4'b0001, "mid_ptr_reset");
    step();
    idle(LATENCY + 2);

    // Idle window
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_ready", req_ready, '0);
      check("idle_tanh_in", tanh_in, '0);
      check("idle_rsp_valid", rsp_valid, '0);
      check("idle_busy", busy, 1'b0);
      step();
    end

    idle(LATENCY + 3);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
